// File: rtl/led_blink_bank.sv
// Bank of NUM_CH independent LED channels (OFF / ON / BLINK / PWM) paced by a shared tick prescaler.
// Define LED_BANK_PWM_EN to build PWM mode and duty registers; without it mode 3 behaves as BLINK.
module led_blink_bank #(
  parameter int NUM_CH     = 4,
  parameter int DIV        = 50000,
  parameter int PER_W      = 16,
  parameter int DEF_PERIOD = 499
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                     cfg_mode,
  input  logic [PER_W-1:0]                               cfg_period,
  input  logic [PER_W-1:0]                               cfg_duty,
  output logic                                           tick,
  output logic [NUM_CH-1:0]                              led
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [PER_W-1:0] DEF_P   = PER_W'(DEF_PERIOD);

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_PWM   = 2'd3;

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          tick_q, tick_d;
  logic [NUM_CH-1:0][1:0]        mode_q, mode_d;
  logic [NUM_CH-1:0][PER_W-1:0]  per_q, per_d;
  logic [NUM_CH-1:0][PER_W-1:0]  ph_q, ph_d;
  logic [NUM_CH-1:0]             led_q, led_d;
  logic [PER_W-1:0]              ph_nxt;

`ifdef LED_BANK_PWM_EN
  logic [NUM_CH-1:0][PER_W-1:0]  duty_q, duty_d;
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  // Configuration has no back-pressure: a cycle with cfg_we=1 is exactly one write,
  // always accepted, and a write to a channel wins over a tick in that same cycle.
  always_comb begin
    tick_d = (cnt_q == CNT_MAX);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    mode_d = mode_q;
    per_d  = per_q;
    ph_d   = ph_q;
    led_d  = led_q;
`ifdef LED_BANK_PWM_EN
    duty_d = duty_q;
`endif
    ph_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ph_nxt = (ph_q[i] == per_q[i]) ? '0 : ph_q[i] + 1'b1;
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        mode_d[i] = cfg_mode;
        per_d[i]  = cfg_period;
        ph_d[i]   = '0;
        led_d[i]  = (cfg_mode == M_ON);
`ifdef LED_BANK_PWM_EN
        duty_d[i] = cfg_duty;
`endif
      end else if (tick_q) begin
        case (mode_q[i])
          M_OFF: begin
            ph_d[i]  = '0;
            led_d[i] = 1'b0;
          end
          M_ON: begin
            ph_d[i]  = '0;
            led_d[i] = 1'b1;
          end
`ifdef LED_BANK_PWM_EN
          M_PWM: begin
            ph_d[i]  = ph_nxt;
            led_d[i] = (ph_nxt < duty_q[i]);
          end
`endif
          default: begin
            // BLINK (and mode 3 when PWM is not built): toggle at end of each phase cycle
            ph_d[i] = ph_nxt;
            if (ph_q[i] == per_q[i]) led_d[i] = ~led_q[i];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      mode_q <= {NUM_CH{M_OFF}};
      per_q  <= {NUM_CH{DEF_P}};
      ph_q   <= '0;
      led_q  <= '0;
`ifdef LED_BANK_PWM_EN
      duty_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      mode_q <= mode_d;
      per_q  <= per_d;
      ph_q   <= ph_d;
      led_q  <= led_d;
`ifdef LED_BANK_PWM_EN
      duty_q <= duty_d;
`endif
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

  logic unused_mode_names;
  assign unused_mode_names = ^{M_BLINK, M_PWM};

endmodule

// File: tb/tb_led_blink_bank.sv
// Self-checking bench for led_blink_bank: directed vector table, hand sequences and
// randomized traffic against an arithmetic reference model (tick counts since last write).
module tb_led_blink_bank;

  localparam int NUM_CH = 3;
  localparam int DIV    = 2;
  localparam int PER_W  = 8;
  localparam int DEF_P  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [PER_W-1:0] cfg_period;
  logic [PER_W-1:0] cfg_duty;
  logic             tick;
  logic [NUM_CH-1:0] led;

  always #5 clk = ~clk;

  led_blink_bank #(
    .NUM_CH(NUM_CH), .DIV(DIV), .PER_W(PER_W), .DEF_PERIOD(DEF_P)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .tick(tick), .led(led)
  );

  // ---------------- reference model ----------------
  bit pwm_en;
  int s_cnt;                 // clock edges since reset released
  int m_mode [NUM_CH];
  int m_per  [NUM_CH];
  int m_duty [NUM_CH];
  int m_k    [NUM_CH];       // ticks applied since the last write

  function automatic bit model_tick();
    return (s_cnt > 0) && (s_cnt % DIV == 0);
  endfunction

  function automatic bit model_led(int i);
    int len;
    len = m_per[i] + 1;
    if (m_mode[i] == 0) return 1'b0;
    if (m_mode[i] == 1) return 1'b1;
    if (m_mode[i] == 3 && pwm_en) return (m_k[i] > 0) && ((m_k[i] % len) < m_duty[i]);
    return ((m_k[i] / len) % 2) == 1;
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [NUM_CH:0] exp_q[$];

  task automatic check(input string name, input logic [NUM_CH:0] got, input logic [NUM_CH:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {tick,led}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_led(input string name, input logic [NUM_CH-1:0] exp);
    n_tests++;
    if (led !== exp) begin
      n_fail++;
      $display("FAIL %s: got led=%b expected %b at %0t", name, led, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit we, input int ch, input int mode, input int per,
                       input int duty, input bit r);
    bit t;
    logic [NUM_CH-1:0] e_led;
    rst        = r;
    cfg_we     = we;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = PER_W'(per);
    cfg_duty   = PER_W'(duty);
    t = model_tick();
    @(posedge clk);
    if (r) begin
      s_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i] = 0; m_per[i] = DEF_P; m_duty[i] = 0; m_k[i] = 0;
      end
    end else begin
      s_cnt++;
      for (int i = 0; i < NUM_CH; i++) begin
        if (we && ch == i) begin
          m_mode[i] = mode; m_per[i] = per; m_duty[i] = duty; m_k[i] = 0;
        end else if (t) begin
          m_k[i]++;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) e_led[i] = model_led(i);
    exp_q.push_back({model_tick(), e_led});
    #1;
    cfg_we = 1'b0;
    rst    = 1'b0;
    check("cycle_model", {tick, led}, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int j = 0; j < n; j++) cycle(0, 0, 0, 0, 0, 1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int ch; int mode; int per; int duty; int n_idle; logic [NUM_CH-1:0] exp_led;
  } vec_t;
  vec_t vecs[$];

  initial begin
    logic [5:0] tick_seq;
`ifdef LED_BANK_PWM_EN
    pwm_en = 1'b1;
`else
    pwm_en = 1'b0;
`endif
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
    s_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = 0; m_per[i] = DEF_P; m_duty[i] = 0; m_k[i] = 0;
    end

    // reset for 3 cycles, then tick pattern after release
    do_reset(3);
    check_led("reset_led", 3'b000);
    for (int j = 0; j < 6; j++) begin
      idle(1);
      tick_seq[j] = tick;
    end
    check("tick_pattern", {1'b0, tick_seq[5:3]}, 4'b0101);
    check("tick_pattern_lo", {1'b0, tick_seq[2:0]}, 4'b0010);

    // write issued on the first edge after reset; channel ticks then land every 2nd edge
    vecs.push_back('{0, 2, 3, 0, 0,  3'b000});
    vecs.push_back('{0, 2, 3, 0, 7,  3'b000});
    vecs.push_back('{0, 2, 3, 0, 8,  3'b001});
    vecs.push_back('{0, 2, 3, 0, 16, 3'b000});
    vecs.push_back('{0, 2, 0, 0, 5,  3'b000});
    vecs.push_back('{0, 2, 0, 0, 6,  3'b001});
    vecs.push_back('{1, 3, 4, 2, 10, 3'b010});
    vecs.push_back('{1, 3, 4, 0, 6,  3'b000});
    vecs.push_back('{2, 1, 4, 0, 0,  3'b100});
    vecs.push_back('{3, 1, 4, 0, 3,  3'b000});
`ifdef LED_BANK_PWM_EN
    vecs.push_back('{1, 3, 4, 2, 2,  3'b010});
    vecs.push_back('{1, 3, 4, 2, 4,  3'b000});
    vecs.push_back('{1, 3, 4, 5, 2,  3'b010});
    vecs.push_back('{1, 3, 4, 5, 12, 3'b010});
`else
    vecs.push_back('{1, 3, 4, 2, 2,  3'b000});
    vecs.push_back('{1, 3, 4, 2, 18, 3'b010});
    vecs.push_back('{1, 3, 4, 2, 20, 3'b000});
`endif
    foreach (vecs[v]) begin
      do_reset(2);
      cycle(1, vecs[v].ch, vecs[v].mode, vecs[v].per, vecs[v].duty, 0);
      idle(vecs[v].n_idle);
      check_led($sformatf("vec%0d", v), vecs[v].exp_led);
    end

    // ON then write to nonexistent channel: no change
    do_reset(2);
    cycle(1, 2, 1, 4, 0, 0);
    check_led("ch2_on", 3'b100);
    cycle(1, 3, 0, 0, 0, 0);
    check_led("bad_ch_ignored", 3'b100);
    idle(3);
    check_led("bad_ch_hold", 3'b100);

    // write coinciding with tick: addressed channel discards it, others advance
    do_reset(2);
    cycle(1, 1, 2, 0, 0, 0);
    cycle(1, 0, 2, 0, 0, 0);
    cycle(1, 0, 2, 0, 0, 0);
    check_led("write_vs_tick", 3'b010);
    idle(1);
    check_led("write_vs_tick_hold", 3'b010);
    idle(1);
    check_led("after_tick", 3'b001);

    // reset mid-blink overrides a concurrent write
    cycle(1, 2, 1, 0, 0, 1);
    check("rst_over_write", {tick, led}, 4'b0000);
    idle(6);
    check_led("after_rst_off", 3'b000);

    // randomized traffic against the model
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 199) == 0)
        cycle(0, 0, 0, 0, 0, 1);
      else if ($urandom_range(0, 5) == 0)
        cycle(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
              $urandom_range(0, 7), 0);
      else
        idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
